// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl -- in-order issue/commit/dispatch/retire controller for the
// XIFU coprocessor. A circular table of DEPTH entries tracks every accepted
// instruction until it is written back or discarded.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   issue_*               ID-stage offer (valid/ready), id, sources, destination
//   commit_*              commit or kill of an issued instruction by id
//   disp_valid_o/ready_i  committed instruction handed to EX, disp_id_o = its id
//   wb_valid_i            EX/WB completed the oldest dispatched instruction
//   busy_o                table not empty
//   err_o                 sticky protocol error (bad commit id or stray wb)
module fir_xifu_ctrl #(
  parameter  int DEPTH    = 4,
  parameter  int ID_WIDTH = 4,
  parameter  int NREG     = 4,
  localparam int RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [2*RW-1:0]     issue_rs_i,
  input  logic [1:0]          issue_rs_use_i,
  input  logic [RW-1:0]       issue_rd_i,
  input  logic                issue_rd_we_i,
  input  logic                commit_valid_i,
  input  logic                commit_kill_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  output logic                disp_valid_o,
  input  logic                disp_ready_i,
  output logic [ID_WIDTH-1:0] disp_id_o,
  input  logic                wb_valid_i,
  output logic                busy_o,
  output logic                err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    ST_FREE, ST_ISSUED, ST_COMMITTED, ST_DISPATCHED, ST_KILLED
  } ent_state_e;

  ent_state_e          state_q [DEPTH];
  ent_state_e          state_d [DEPTH];
  logic [ID_WIDTH-1:0] id_q    [DEPTH];
  logic [ID_WIDTH-1:0] id_d    [DEPTH];
  logic [RW-1:0]       rd_q    [DEPTH];
  logic [RW-1:0]       rd_d    [DEPTH];
  logic [DEPTH-1:0]    we_q, we_d;
  logic [PW-1:0]       head_q, head_d, dsp_q, dsp_d, tail_q, tail_d;
  // count_q: occupied entries; dcnt_q: entries in [dsp, tail) not yet passed
  // by the dispatch pointer. Tracking dcnt avoids the dsp==tail ambiguity
  // when the table is full.
  logic [CW-1:0]       count_q, count_d, dcnt_q, dcnt_d;
  logic [NREG-1:0]     pend_q, pend_d;
  logic                err_q, err_d;
  // A kill releases the destination register one edge after the kill lands.
  logic                kclr_q, kclr_d;
  logic [RW-1:0]       krd_q, krd_d;

  logic                hazard, issue_fire, disp_fire, dsp_adv, ret_fire;
  logic                cm_hit;
  logic [PW-1:0]       cm_idx, scan_idx;
  logic [CW-1:0]       behind;

  assign hazard = (issue_rs_use_i[0] & pend_q[issue_rs_i[RW-1:0]])
                | (issue_rs_use_i[1] & pend_q[issue_rs_i[2*RW-1:RW]])
                | (issue_rd_we_i     & pend_q[issue_rd_i]);
  assign issue_ready_o = (count_q < CW'(DEPTH)) & ~hazard;
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign disp_valid_o  = (dcnt_q != '0) && (state_q[dsp_q] == ST_COMMITTED);
  assign disp_id_o     = id_q[dsp_q];
  assign disp_fire     = disp_valid_o & disp_ready_i;
  assign busy_o        = (count_q != '0);
  assign err_o         = err_q;
  assign behind        = count_q - dcnt_q;  // dispatched/skipped, not retired

  // Oldest-first search for the ISSUED entry named by the commit.
  always_comb begin
    cm_hit   = 1'b0;
    cm_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (!cm_hit && state_q[scan_idx] == ST_ISSUED && id_q[scan_idx] == commit_id_i) begin
        cm_hit = 1'b1;
        cm_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rd_d     = rd_q;
    we_d     = we_q;
    head_d   = head_q;
    dsp_d    = dsp_q;
    tail_d   = tail_q;
    pend_d   = pend_q;
    err_d    = err_q;
    kclr_d   = 1'b0;
    krd_d    = krd_q;
    dsp_adv  = 1'b0;
    ret_fire = 1'b0;

    if (kclr_q) pend_d[krd_q] = 1'b0;

    if (commit_valid_i) begin
      if (cm_hit) begin
        state_d[cm_idx] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
        if (commit_kill_i && we_q[cm_idx]) begin
          kclr_d = 1'b1;
          krd_d  = rd_q[cm_idx];
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Dispatch pointer: hand out a committed entry or step over a killed one.
    if (disp_fire) begin
      state_d[dsp_q] = ST_DISPATCHED;
      dsp_adv        = 1'b1;
    end else if (dcnt_q != '0 && state_q[dsp_q] == ST_KILLED) begin
      dsp_adv = 1'b1;
    end

    // Retire pointer: a writeback owns the cycle; otherwise drain a killed
    // entry the dispatch pointer has already passed.
    if (wb_valid_i) begin
      if (behind != '0 && state_q[head_q] == ST_DISPATCHED) begin
        state_d[head_q] = ST_FREE;
        if (we_q[head_q]) pend_d[rd_q[head_q]] = 1'b0;
        ret_fire = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (behind != '0 && state_q[head_q] == ST_KILLED) begin
      state_d[head_q] = ST_FREE;
      ret_fire        = 1'b1;
    end

    // Allocation last so a same-edge set of a pending bit wins over a clear.
    if (issue_fire) begin
      state_d[tail_q] = ST_ISSUED;
      id_d[tail_q]    = issue_id_i;
      rd_d[tail_q]    = issue_rd_i;
      we_d[tail_q]    = issue_rd_we_i;
      if (issue_rd_we_i) pend_d[issue_rd_i] = 1'b1;
      tail_d = tail_q + PW'(1);
    end

    if (dsp_adv)  dsp_d  = dsp_q + PW'(1);
    if (ret_fire) head_d = head_q + PW'(1);
    count_d = count_q + CW'(issue_fire) - CW'(ret_fire);
    dcnt_d  = dcnt_q + CW'(issue_fire) - CW'(dsp_adv);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
      end
      we_q    <= '0;
      head_q  <= '0;
      dsp_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dcnt_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      kclr_q  <= 1'b0;
      krd_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      head_q  <= head_d;
      dsp_q   <= dsp_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      kclr_q  <= kclr_d;
      krd_q   <= krd_d;
    end
  end
endmodule

// File: doc/fir_xifu_ctrl.md
FIR_XIFU_CTRL -- requirements
Module: fir_xifu_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, in-flight table entries (power of 2, >= 2).
REQ-002 Parameter ID_WIDTH, default 4, X-interface instruction ID width.
REQ-003 Parameter NREG, default 4, XIFU internal registers; index width RW = clog2(NREG).
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous reset, active-high.
REQ-006 issue_valid_i  input  1  decoded XIFU instruction offered by ID stage.
REQ-007 issue_ready_o  output  1  controller accepts the issue; transfer when valid & ready.
REQ-008 issue_id_i  input  ID_WIDTH  instruction ID.
REQ-009 issue_rs_i  input  2*RW  two internal source register indices; issue_rs_use_i (input, 2) flags each as used.
REQ-010 issue_rd_i  input  RW  internal destination register; issue_rd_we_i (input, 1) flags a write.
REQ-011 commit_valid_i, commit_kill_i  input  1 each  commit event; kill = 1 discards the instruction.
REQ-012 commit_id_i  input  ID_WIDTH  ID being committed or killed.
REQ-013 disp_valid_o  output  1  committed instruction ready to enter EX.
REQ-014 disp_ready_i  input  1  EX accepts dispatch; disp_id_o (output, ID_WIDTH) carries the ID.
REQ-015 wb_valid_i  input  1  EX/WB completed the oldest dispatched instruction.
REQ-016 busy_o  output  1  any entry non-FREE; err_o  output  1  sticky protocol error.

Function
REQ-017 Circular table with pointers head (retire), dsp (dispatch), tail (alloc) and count 0..DEPTH; per entry: state, id, rd, rd_we.
REQ-018 Entry states: FREE, ISSUED, COMMITTED, DISPATCHED, KILLED.
REQ-019 issue_ready_o = (count < DEPTH) & no hazard; hazard = pending[rs_k] for any used source, or pending[rd] when rd_we; computed from registered state only (no bypass).
REQ-020 Accepted issue: entry[tail] <- ISSUED with id/rd/rd_we, tail++, count++, pending[rd] <- 1 if rd_we.
REQ-021 Commit: entry with state ISSUED and matching id -> COMMITTED (kill=0) or KILLED (kill=1); killed entry clears its pending[rd] the following edge.
REQ-022 Commit with no matching ISSUED entry -> ignored, err_o set (sticky until reset).
REQ-023 disp_valid_o = 1 iff dsp != tail (or count = DEPTH) and entry[dsp] is COMMITTED; disp_id_o = entry[dsp].id.
REQ-024 disp_valid_o & disp_ready_i -> entry[dsp] DISPATCHED, dsp++; disp_valid_o held stable until accepted.
REQ-025 entry[dsp] KILLED -> dsp++ without dispatch, one entry per cycle.
REQ-026 wb_valid_i: entry[head] must be DISPATCHED -> FREE, clear pending[rd] if rd_we, head++, count--; otherwise ignored and err_o set.
REQ-027 entry[head] KILLED and head != dsp -> FREE, head++, count--, one per cycle; wb retirement takes priority over killed drain in the same cycle.
REQ-028 Same-cycle issue and retire: count unchanged, both take effect; a pending bit set and cleared on one edge for different entries resolves set-wins.
REQ-029 Commit of an entry being allocated the same cycle is not matched (registered lookup); commit→dispatch latency minimum 1 cycle; issue→dispatch minimum 2 cycles.
REQ-030 Pointer wrap modulo DEPTH; full = count == DEPTH; busy_o = count != 0.

Reset
REQ-031 rst_i asserted (any time, incl. mid-operation): all entries FREE, pointers/count 0, pending 0, err_o 0, disp_valid_o 0, issue_ready_o 1 in the cycle after release; in-flight instructions are dropped.

Verification
REQ-032 Issue id 3 (rd 1, we), commit id 3 -> disp_valid_o one cycle later with disp_id_o = 3; wb -> busy_o 0, pending[1] 0.
REQ-033 Four issues without commit -> issue_ready_o 0 at count 4; one commit+dispatch+wb -> issue_ready_o 1 next cycle.
REQ-034 Issue id 1 writing r2, then issue reading r2 -> issue_ready_o 0 until wb of id 1, then accepted.
REQ-035 Issue ids 5,6,7, kill id 6, commit 5 and 7 -> dispatch order 5,7; id 6 never dispatched; table drains to empty.
REQ-036 Commit id 9 never issued -> err_o 1, state unchanged; wb_valid_i with empty table -> err_o 1.
REQ-037 Reset asserted with 3 entries in flight -> outputs at reset values, subsequent issue id 0 dispatches normally.
